sub_pipe: RTL and testbench

SUB_PIPE -- requirements
Module: sub_pipe

---
 rtl/sub_pipe.sv | 154 +++++++++++++++
 tb/tb_sub_pipe.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sub_pipe.sv
// sub_pipe: two-stage pipelined subtractor with valid/ready handshakes on both sides.
//
// Stage 1 registers the operands and mode. Stage 2 registers the result and flags.
// The mode selects unsigned or signed arithmetic, with either wrap or saturate.
//
// Ports
//   clk        in   clock; all state updates on the rising edge
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   in1/in2/mode carry an operation
//   in_ready   out  an operation is accepted this cycle
//   in1        in   minuend
//   in2        in   subtrahend
//   mode       in   00 uns wrap, 01 uns sat, 10 signed wrap, 11 signed sat
//   out_valid  out  out and the flags hold a result
//   out_ready  in   downstream takes the result this cycle
//   out        out  registered result
//   borrow     out  unsigned borrow (in1 < in2)
//   ovf        out  overflow for the selected mode
//   sat        out  a saturation clamp was applied
//   zero       out  out == 0 after clamping
module sub_pipe #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [1:0]       mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    output logic             borrow,
    output logic             ovf,
    output logic             sat,
    output logic             zero
);

    logic             s1_v_q;
    logic [WIDTH-1:0] in1_q;
    logic [WIDTH-1:0] in2_q;
    logic [1:0]       mode_q;

    logic             s2_v_q;
    logic [WIDTH-1:0] out_q;
    logic             borrow_q;
    logic             ovf_q;
    logic             sat_q;
    logic             zero_q;

    logic             adv1;
    logic             adv2;
    logic             in_fire;

    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] raw;
    logic             borrow_d;
    logic             sovf;
    logic [WIDTH-1:0] out_d;
    logic             ovf_d;
    logic             sat_d;
    logic             zero_d;

    assign adv2     = !s2_v_q || out_ready;
    assign adv1     = !s1_v_q || adv2;
    assign in_ready = adv1;
    assign in_fire  = in_valid && adv1;

    // One extra bit on the difference yields the unsigned borrow directly.
    assign diff     = {1'b0, in1_q} - {1'b0, in2_q};
    assign borrow_d = diff[WIDTH];
    assign raw      = diff[WIDTH-1:0];
    assign sovf     = (in1_q[WIDTH-1] != in2_q[WIDTH-1]) && (raw[WIDTH-1] != in1_q[WIDTH-1]);

    always_comb begin
        out_d = raw;
        ovf_d = borrow_d;
        sat_d = 1'b0;
        unique case (mode_q)
            2'b00: begin
                ovf_d = borrow_d;
            end
            2'b01: begin
                ovf_d = borrow_d;
                if (borrow_d) begin
                    out_d = '0;
                    sat_d = 1'b1;
                end
            end
            2'b10: begin
                ovf_d = sovf;
            end
            default: begin
                ovf_d = sovf;
                if (sovf) begin
                    // Clamp toward the sign of the minuend.
                    out_d = in1_q[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                           : {1'b0, {(WIDTH-1){1'b1}}};
                    sat_d = 1'b1;
                end
            end
        endcase
        zero_d = (out_d == '0);
    end

    // Operand registers carry no reset; s1_v_q qualifies them.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            in1_q  <= in1;
            in2_q  <= in2;
            mode_q <= mode;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_v_q <= 1'b0;
        end else if (in_fire) begin
            s1_v_q <= 1'b1;
        end else if (adv2) begin
            s1_v_q <= 1'b0;
        end
    end

    // Result registers load only real data so stale operands never reach out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_v_q   <= 1'b0;
            out_q    <= '0;
            borrow_q <= 1'b0;
            ovf_q    <= 1'b0;
            sat_q    <= 1'b0;
            zero_q   <= 1'b1;
        end else if (adv2) begin
            s2_v_q <= s1_v_q;
            if (s1_v_q) begin
                out_q    <= out_d;
                borrow_q <= borrow_d;
                ovf_q    <= ovf_d;
                sat_q    <= sat_d;
                zero_q   <= zero_d;
            end
        end
    end

    assign out_valid = s2_v_q;
    assign out       = out_q;
    assign borrow    = borrow_q;
    assign ovf       = ovf_q;
    assign sat       = sat_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_sub_pipe.sv
module tb_sub_pipe;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in1;
    logic [15:0] in2;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out;
    logic        borrow;
    logic        ovf;
    logic        sat;
    logic        zero;

    int total = 0;
    int bad   = 0;

    sub_pipe #(.WIDTH(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out),
        .borrow    (borrow),
        .ovf       (ovf),
        .sat       (sat),
        .zero      (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [19:0] res_vec();
        return {out, borrow, ovf, sat, zero};
    endfunction

    // Reference built on integer arithmetic: {out, borrow, ovf, sat, zero}.
    function automatic logic [19:0] model(input logic [1:0] m, input logic [15:0] a,
                                          input logic [15:0] b);
        int ua = a;
        int ub = b;
        int sa = $signed(a);
        int sb = $signed(b);
        int ud;
        int sd;
        logic [15:0] r;
        logic bo;
        logic ov;
        logic st;
        ud = ua - ub;
        sd = sa - sb;
        bo = (ua < ub);
        r  = ud[15:0];
        ov = m[1] ? (sd > 32767 || sd < -32768) : bo;
        st = 1'b0;
        if (m == 2'b01 && bo) begin
            r  = 16'h0000;
            st = 1'b1;
        end
        if (m == 2'b11 && ov) begin
            r  = (sd < 0) ? 16'h8000 : 16'h7FFF;
            st = 1'b1;
        end
        return {r, bo, ov, st, (r == 16'h0000)};
    endfunction

    // Called just after a rising edge with stage 1 empty; out_ready held high.
    task automatic run_op(input string tag, input logic [1:0] m, input logic [15:0] a,
                          input logic [15:0] b, input logic [19:0] exp);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        mode      = m;
        in1       = a;
        in2       = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, "_lat1"}, out_valid, 1'b0);
        @(posedge clk); #1;
        chk({tag, "_lat2"}, out_valid, 1'b1);
        chk(tag, res_vec(), exp);
    endtask

    logic [1:0]  s_m   [8];
    logic [15:0] s_a   [8];
    logic [15:0] s_b   [8];
    logic [19:0] s_exp [8];

    initial begin
        int sent;
        int rcvd;
        int occ;
        logic in_fire;
        logic out_fire;
        logic stall_prev;
        logic [19:0] prev_val;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in1       = 16'h0;
        in2       = 16'h0;
        mode      = 2'b00;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_outputs", res_vec(), 20'h00001);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_in_ready", in_ready, 1'b1);
        chk("post_rst_out_valid", out_valid, 1'b0);

        // Directed vectors; expected = {out, borrow, ovf, sat, zero}.
        run_op("uwrap_5m7",   2'b00, 16'h0005, 16'h0007, 20'hFFFEC);
        run_op("usat_5m7",    2'b01, 16'h0005, 16'h0007, 20'h0000F);
        run_op("usat_1234",   2'b01, 16'h1234, 16'h0234, 20'h10000);
        run_op("ssat_neg",    2'b11, 16'h8000, 16'h0001, 20'h80006);
        run_op("ssat_pos",    2'b11, 16'h7FFF, 16'hFFFF, 20'h7FFFE);
        run_op("swrap_pos",   2'b10, 16'h7FFF, 16'hFFFF, 20'h8000C);
        run_op("swrap_neg",   2'b10, 16'h8000, 16'h0001, 20'h7FFF4);
        run_op("uwrap_eq",    2'b00, 16'h0009, 16'h0009, 20'h00001);
        run_op("ssat_noovf",  2'b11, 16'h0003, 16'h0005, 20'hFFFE8);
        @(posedge clk); #1;
        chk("drained", out_valid, 1'b0);

        for (int i = 0; i < 8; i++) begin
            s_m[i]   = 2'($urandom_range(0, 3));
            s_a[i]   = 16'($urandom);
            s_b[i]   = 16'($urandom);
            s_exp[i] = model(s_m[i], s_a[i], s_b[i]);
        end

        sent       = 0;
        rcvd       = 0;
        occ        = 0;
        stall_prev = 1'b0;
        prev_val   = '0;
        for (int cyc = 0; cyc < 300 && rcvd < 8; cyc++) begin
            in_valid  = (sent < 8);
            if (sent < 8) begin
                mode = s_m[sent];
                in1  = s_a[sent];
                in2  = s_b[sent];
            end
            out_ready = 1'($urandom_range(0, 1));
            #1;
            chk("stream_in_ready", in_ready, !(occ == 2 && !out_ready));
            if (stall_prev) chk("stream_stable", {out_valid, res_vec()}, {1'b1, prev_val});
            if (out_valid) chk("stream_result", res_vec(), s_exp[rcvd]);
            in_fire    = in_valid && in_ready;
            out_fire   = out_valid && out_ready;
            stall_prev = out_valid && !out_ready;
            prev_val   = res_vec();
            @(posedge clk); #1;
            if (in_fire) begin
                sent++;
                occ++;
            end
            if (out_fire) begin
                rcvd++;
                occ--;
            end
        end
        chk("stream_count", rcvd, 8);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("stream_empty", out_valid, 1'b0);

        // Two operations in flight, then reset before the result is consumed.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        mode      = 2'b00;
        in1       = 16'h0100;
        in2       = 16'h0001;
        @(posedge clk); #1;
        in1 = 16'h0200;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("pre_rst_full", out_valid, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 1'b0);
        chk("midrst_outputs", res_vec(), 20'h00001);
        chk("midrst_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("after_rst_v0", out_valid, 1'b0);
        @(posedge clk); #1;
        chk("after_rst_v1", out_valid, 1'b0);
        run_op("after_rst_op", 2'b01, 16'h0050, 16'h0010, 20'h00400);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
